peripheral_adder_pipe: RTL and testbench

PERIPHERAL_ADDER_PIPE -- requirements
Module: peripheral_adder_pipe

---
 rtl/peripheral_adder_pkg.sv | 22 ++
 rtl/peripheral_adder_alu.sv | 56 +++++
 rtl/peripheral_adder_pipe.sv | 138 +++++++++++++
 tb/tb_peripheral_adder_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_adder_pkg.sv
// Shared mode encodings, default sizing constants and a channel-width helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: mode_e (2-bit op select), DEF_DATA_WIDTH, DEF_CHANNELS, chan_width().
package peripheral_adder_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CHANNELS   = 4;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,  // wrapping add, flag = carry
      MODE_SAT = 2'b01,  // unsigned saturating add, flag = clamped
      MODE_ACC = 2'b10,  // per-channel accumulate, flag = carry
      MODE_SUB = 2'b11   // wrapping subtract a-b, flag = borrow
   } mode_e;

   // Tag width; a single channel still needs a 1-bit tag port.
   function automatic int chan_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/peripheral_adder_alu.sv
// Combinational arithmetic for all four modes, producing result and flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: i_mode op select, i_a/i_b operands, i_acc accumulator value for
//        MODE_ACC (i_b ignored there), o_res result, o_ovf carry/clamp/borrow.
module peripheral_adder_alu
   import peripheral_adder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  mode_e                 i_mode,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [DATA_WIDTH-1:0] i_acc,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_ovf
);

   logic [DATA_WIDTH:0] w_sum;
   logic [DATA_WIDTH:0] w_diff;
   logic [DATA_WIDTH:0] w_acc_sum;

   // One extra bit holds the carry; for the subtract it is set exactly
   // when the zero-extended difference goes negative, i.e. i_b > i_a.
   assign w_sum     = {1'b0, i_a}   + {1'b0, i_b};
   assign w_diff    = {1'b0, i_a}   - {1'b0, i_b};
   assign w_acc_sum = {1'b0, i_acc} + {1'b0, i_a};

   always_comb begin
      o_res = w_sum[DATA_WIDTH-1:0];
      o_ovf = w_sum[DATA_WIDTH];
      case (i_mode)
         MODE_ADD: begin
            o_res = w_sum[DATA_WIDTH-1:0];
            o_ovf = w_sum[DATA_WIDTH];
         end
         MODE_SAT: begin
            o_res = w_sum[DATA_WIDTH] ? '1 : w_sum[DATA_WIDTH-1:0];
            o_ovf = w_sum[DATA_WIDTH];
         end
         MODE_ACC: begin
            o_res = w_acc_sum[DATA_WIDTH-1:0];
            o_ovf = w_acc_sum[DATA_WIDTH];
         end
         MODE_SUB: begin
            o_res = w_diff[DATA_WIDTH-1:0];
            o_ovf = w_diff[DATA_WIDTH];
         end
         default: begin
            o_res = w_sum[DATA_WIDTH-1:0];
            o_ovf = w_sum[DATA_WIDTH];
         end
      endcase
   end

endmodule

// File: rtl/peripheral_adder_pipe.sv
// Two-stage adder pipe (compute, output) with per-channel accumulators and a
// delivered-result counter. Latency: 2 edges accept->out_valid, 1/cycle.
// Backpressure: out_ready stall holds S2; S1 refills only when S2 frees.
// Ports: clk, rst (async active-low); in_valid/in_ready, in1, in2, in_chan,
//        mode, acc_clr upstream; out_valid/out_ready, out, out_chan, out_ovf
//        downstream; txn_count = number of results delivered (16-bit wrap).
module peripheral_adder_pipe
   import peripheral_adder_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int CHANNELS   = DEF_CHANNELS,
   localparam int CW         = chan_width(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic [CW-1:0]         in_chan,
   input  logic [1:0]            mode,
   input  logic                  acc_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic [CW-1:0]         out_chan,
   output logic                  out_ovf,
   output logic [15:0]           txn_count
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] dat;
      logic [CW-1:0]         chan;
      logic                  ovf;
   } res_t;

   mode_e                 w_mode;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_s2_free;
   logic                  w_s1_move;
   logic [CW-1:0]         w_acc_idx;
   logic [DATA_WIDTH-1:0] w_acc_rd;
   logic [DATA_WIDTH-1:0] w_alu_res;
   logic                  w_alu_ovf;

   logic                  r_s1_vld;
   res_t                  r_s1;
   logic                  r_s2_vld;
   res_t                  r_s2;
   logic [DATA_WIDTH-1:0] r_acc [CHANNELS];
   logic [15:0]           r_txn_cnt;

   assign w_mode = mode_e'(mode);

   // Handshake: S2 can take a new entry when empty or draining this edge;
   // S1 can take a new entry when empty or moving into S2 this edge.
   assign w_s2_free  = !r_s2_vld || out_ready;
   assign w_s1_move  = r_s1_vld && w_s2_free;
   assign in_ready   = !r_s1_vld || w_s1_move;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_s2_vld && out_ready;

   // Out-of-range tags fold onto channel 0 for the accumulator only; the
   // original tag still travels with the result.
   assign w_acc_idx = ({1'b0, in_chan} < (CW+1)'(CHANNELS)) ? in_chan : '0;

   // A clear on the same edge as an accumulate means the op starts from 0.
   // The accumulator is written on the accepting edge, so the next accepted
   // op on the same channel already reads the updated value.
   assign w_acc_rd = acc_clr ? '0 : r_acc[w_acc_idx];

   peripheral_adder_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .i_mode (w_mode),
      .i_a    (in1),
      .i_b    (in2),
      .i_acc  (w_acc_rd),
      .o_res  (w_alu_res),
      .o_ovf  (w_alu_ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_vld <= 1'b0;
         r_s1     <= '0;
      end else if (w_in_fire) begin
         r_s1_vld  <= 1'b1;
         r_s1.dat  <= w_alu_res;
         r_s1.chan <= in_chan;
         r_s1.ovf  <= w_alu_ovf;
      end else if (w_s1_move) begin
         r_s1_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_vld <= 1'b0;
         r_s2     <= '0;
      end else if (w_s1_move) begin
         r_s2_vld <= 1'b1;
         r_s2     <= r_s1;
      end else if (w_out_fire) begin
         r_s2_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      end else begin
         if (acc_clr) begin
            for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
         end
         // Later assignment wins over the clear for the channel being used.
         if (w_in_fire && (w_mode == MODE_ACC)) begin
            r_acc[w_acc_idx] <= w_alu_res;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_txn_cnt <= '0;
      end else if (w_out_fire) begin
         r_txn_cnt <= r_txn_cnt + 16'd1;
      end
   end

   assign out_valid = r_s2_vld;
   assign out       = r_s2.dat;
   assign out_chan  = r_s2.chan;
   assign out_ovf   = r_s2.ovf;
   assign txn_count = r_txn_cnt;

endmodule

// File: tb/tb_peripheral_adder_pipe.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and randomized traffic scored against a transfer-level reference model.
module tb_peripheral_adder_pipe;
   import peripheral_adder_pkg::*;

   localparam int DW  = 8;
   localparam int CH  = 4;
   localparam int CW  = 2;
   localparam int LIM = 1 << DW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in1;
   logic [DW-1:0] in2;
   logic [CW-1:0] in_chan;
   logic [1:0]    mode;
   logic          acc_clr;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out;
   logic [CW-1:0] out_chan;
   logic          out_ovf;
   logic [15:0]   txn_count;

   peripheral_adder_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .in_chan   (in_chan),
      .mode      (mode),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_chan  (out_chan),
      .out_ovf   (out_ovf),
      .txn_count (txn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    mode;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [CW-1:0] ch;
      logic          clr;
      logic [DW-1:0] eo;
      logic          eovf;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          v;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;
   int   mcount = 0;
   exp_t q[$];
   int   acc_m[CH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: works per transfer with plain integer arithmetic.
   exp_t m_e;
   int   m_sum;
   int   m_c;
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         for (int i = 0; i < CH; i++) acc_m[i] = 0;
         mcount = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", 64'(1), 64'(0));
            end else begin
               m_e = q.pop_front();
               check("model_out", 64'(out), 64'(m_e.d));
               check("model_chan", 64'(out_chan), 64'(m_e.c));
               check("model_ovf", 64'(out_ovf), 64'(m_e.v));
               n_out++;
               mcount++;
            end
         end
         m_c = (int'(in_chan) < CH) ? int'(in_chan) : 0;
         if (in_valid && in_ready) begin
            case (mode)
               2'b00: begin
                  m_sum = int'(in1) + int'(in2);
                  m_e.d = DW'(m_sum % LIM);
                  m_e.v = (m_sum >= LIM);
               end
               2'b01: begin
                  m_sum = int'(in1) + int'(in2);
                  m_e.d = (m_sum >= LIM) ? DW'(LIM - 1) : DW'(m_sum);
                  m_e.v = (m_sum >= LIM);
               end
               2'b11: begin
                  m_sum = int'(in1) - int'(in2);
                  m_e.d = DW'((m_sum + LIM) % LIM);
                  m_e.v = (in2 > in1);
               end
               default: begin
                  m_sum = (acc_clr ? 0 : acc_m[m_c]) + int'(in1);
                  m_e.d = DW'(m_sum % LIM);
                  m_e.v = (m_sum >= LIM);
               end
            endcase
            m_e.c = in_chan;
            q.push_back(m_e);
         end
         if (acc_clr) for (int i = 0; i < CH; i++) acc_m[i] = 0;
         if (in_valid && in_ready && mode == 2'b10) acc_m[m_c] = int'(m_e.d);
      end
   end

   // Caller is at posedge+1 with an idle pipe; returns at posedge+1 idle.
   task automatic run_single(input vec_t v, input string tag);
      int lat;
      lat = -1;
      mode = v.mode; in1 = v.a; in2 = v.b; in_chan = v.ch; acc_clr = v.clr;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; acc_clr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            check({tag, "_out"}, 64'(out), 64'(v.eo));
            check({tag, "_ovf"}, 64'(out_ovf), 64'(v.eovf));
            check({tag, "_chan"}, 64'(out_chan), 64'(v.ch));
            break;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic drain(input string tag);
      int k;
      in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
      k = 0;
      while ((q.size() != 0 || out_valid) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_drain_timeout"}, 64'(k < 20), 64'(1));
   endtask

   vec_t          tbl[13];
   logic [DW-1:0] got[3];
   logic [DW+CW:0] held;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{2'b00, 8'hF0, 8'h20, 2'd0, 1'b0, 8'h10, 1'b1};
      tbl[1]  = '{2'b01, 8'hF0, 8'h20, 2'd1, 1'b0, 8'hFF, 1'b1};
      tbl[2]  = '{2'b01, 8'h10, 8'h20, 2'd2, 1'b0, 8'h30, 1'b0};
      tbl[3]  = '{2'b11, 8'h10, 8'h20, 2'd3, 1'b0, 8'hF0, 1'b1};
      tbl[4]  = '{2'b10, 8'h05, 8'hAA, 2'd2, 1'b0, 8'h05, 1'b0};
      tbl[5]  = '{2'b10, 8'h05, 8'h55, 2'd2, 1'b0, 8'h0A, 1'b0};
      tbl[6]  = '{2'b10, 8'h05, 8'h00, 2'd2, 1'b0, 8'h0F, 1'b0};
      tbl[7]  = '{2'b10, 8'h03, 8'h11, 2'd2, 1'b1, 8'h03, 1'b0};
      tbl[8]  = '{2'b10, 8'h01, 8'h00, 2'd1, 1'b0, 8'h01, 1'b0};
      tbl[9]  = '{2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 8'h00, 1'b0};
      tbl[10] = '{2'b11, 8'h20, 8'h20, 2'd1, 1'b0, 8'h00, 1'b0};
      tbl[11] = '{2'b01, 8'hFF, 8'h00, 2'd0, 1'b0, 8'hFF, 1'b0};
      tbl[12] = '{2'b10, 8'hFE, 8'h00, 2'd2, 1'b0, 8'h01, 1'b1};

      rst = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; in_chan = '0;
      mode = 2'b00; acc_clr = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out", 64'(out), 64'(0));
      check("rst_out_chan", 64'(out_chan), 64'(0));
      check("rst_out_ovf", 64'(out_ovf), 64'(0));
      check("rst_txn_count", 64'(txn_count), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      check("rst_in_ready", 64'(in_ready), 64'(1));

      // Vector 0 is accepted on the first edge after reset release.
      for (int i = 0; i < 13; i++) run_single(tbl[i], $sformatf("tbl%0d", i));

      // Back-to-back accumulate on one channel; in2 must be ignored.
      begin
         int n;
         n = 0;
         for (int k = 0; k < 8; k++) begin
            in_valid = (k < 3); mode = 2'b10; in_chan = 2'd3;
            in1 = 8'h05; in2 = DW'($urandom);
            @(negedge clk);
            if (out_valid) begin
               if (n < 3) got[n] = out;
               n++;
            end
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         check("b2b_count", 64'(n), 64'(3));
         check("b2b_out0", 64'(got[0]), 64'(8'h05));
         check("b2b_out1", 64'(got[1]), 64'(8'h0A));
         check("b2b_out2", 64'(got[2]), 64'(8'h0F));
      end

      // Stream of 8 with a 4-cycle downstream stall in the middle.
      do_reset();
      begin
         int  sent, cyc, n0;
         bit  have, saw_full;
         sent = 0; cyc = 0; n0 = n_out; have = 0; saw_full = 0; held = '0;
         while (sent < 8 && cyc < 100) begin
            in_valid = 1'b1; mode = 2'b00;
            in1 = DW'($urandom); in2 = DW'($urandom); in_chan = CW'($urandom);
            out_ready = !(cyc >= 3 && cyc < 7);
            @(negedge clk);
            if (!in_ready) saw_full = 1;
            if (out_valid && !out_ready) begin
               if (have) check("stall_hold", 64'({out_chan, out_ovf, out}), 64'(held));
               held = {out_chan, out_ovf, out};
               have = 1;
            end
            if (in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
         end
         check("bp_sent", 64'(sent), 64'(8));
         check("bp_in_ready_low", 64'(saw_full), 64'(1));
         drain("bp");
         check("bp_delivered", 64'(n_out - n0), 64'(8));
         check("bp_txn_count", 64'(txn_count), 64'(8));
      end

      // Randomized traffic with random backpressure and occasional clears.
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom % 4) != 0;
         mode      = 2'($urandom);
         in_chan   = CW'($urandom);
         in1       = DW'($urandom);
         in2       = DW'($urandom);
         acc_clr   = ($urandom % 16) == 0;
         out_ready = ($urandom % 4) != 0;
         @(posedge clk); #1;
      end
      drain("rand");
      check("rand_txn_count", 64'(txn_count), 64'(16'(mcount)));

      // Reset with both stages full, accumulator 0 non-zero.
      out_ready = 1'b0; in_valid = 1'b1; mode = 2'b10; in_chan = 2'd0;
      in1 = 8'h11; acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("full_out_valid", 64'(out_valid), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_txn_count", 64'(txn_count), 64'(0));
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1; out_ready = 1'b1;
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      begin
         vec_t v;
         v = '{2'b10, 8'h07, 8'h33, 2'd0, 1'b0, 8'h07, 1'b0};
         run_single(v, "post_rst_acc");
      end
      check("post_rst_txn_count", 64'(txn_count), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
